tx_framed: RTL



---
 rtl/tx_framed.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tx_framed.sv
// UART transmitter: one word per valid/ready transfer, framed as start, data (LSB first),
// optional parity and one or two stop bits. pin, busy and done are registered.
module tx_framed #(
  parameter int CLOCK_HZ  = 12_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 valid,
  output logic                 ready,
  input  logic [DATA_BITS-1:0] data,
  output logic                 busy,
  output logic                 done,
  output logic                 pin,
  output logic [2:0]           dbg_state
);

  localparam int CYCLES_PER_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int CW = $clog2(CYCLES_PER_BIT) + 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(CYCLES_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  generate
    if (CYCLES_PER_BIT < 2) begin : g_bad_baud
      $error("tx_framed: CLOCK_HZ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
      $error("tx_framed: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("tx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("tx_framed: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_pin;
  logic                 r_busy;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [IW-1:0]        w_idx_nxt;
  logic                 w_stop_nxt;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 w_pin_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;
  logic                 w_bit_end;
  logic                 w_parity;

  // Handshake: a word transfers on a rising edge where valid && ready; ready is high only in
  // IDLE, so valid offered while a frame is in flight is simply not seen.
  assign ready     = (r_state == S_IDLE);
  assign busy      = r_busy;
  assign done      = r_done;
  assign pin       = r_pin;
  assign dbg_state = r_state;

  assign w_bit_end = (r_cnt == LAST_CNT);
  // Odd parity makes the total count of ones odd, even parity makes it even.
  assign w_parity  = (PARITY == 1) ? ~(^r_data) : (^r_data);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_stop_nxt  = r_stop_idx;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;

    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_bit_end ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (valid) begin
          w_state_nxt = S_START;
          w_data_nxt  = data;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_stop_nxt  = 1'b0;
            w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_stop_nxt  = 1'b0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (STOP_BITS == 1 || r_stop_idx) begin
            w_state_nxt = S_IDLE;
            w_stop_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_stop_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
        w_stop_nxt  = 1'b0;
      end
    endcase
  end

  // Outputs are computed from the next state so the registered pin shows the
  // start bit in the cycle right after the accepting edge.
  always_comb begin
    w_pin_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_pin_nxt = 1'b0;
      S_DATA:   w_pin_nxt = r_data[w_idx_nxt];
      S_PARITY: w_pin_nxt = w_parity;
      default:  w_pin_nxt = 1'b1;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_data     <= '0;
      r_pin      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_stop_idx <= w_stop_nxt;
      r_data     <= w_data_nxt;
      r_pin      <= w_pin_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

endmodule
